// File: rtl/keypad_operand_reg.sv
// Keypad operand entry: shifts BCD digits into operand A, then B, latches an operator and
// presents A-op-B to the arithmetic stage through a valid/ack handshake.
module keypad_operand_reg #(
  parameter int unsigned NDIGIT    = 4,
  parameter logic [3:0]  KEY_ADD   = 4'hA,
  parameter logic [3:0]  KEY_SUB   = 4'hB,
  parameter logic [3:0]  KEY_MUL   = 4'hC,
  parameter logic [3:0]  KEY_CLR   = 4'hD,
  parameter logic [3:0]  KEY_BKSP  = 4'hE,
  parameter logic [3:0]  KEY_ENTER = 4'hF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          key_in,
  input  logic                key_valid,
  input  logic                req_ack,
  output logic [4*NDIGIT-1:0] operand_a,
  output logic [4*NDIGIT-1:0] operand_b,
  output logic [1:0]          op_code,
  output logic                req_valid,
  output logic [4*NDIGIT-1:0] disp,
  output logic [NDIGIT-1:0]   disp_blank,
  output logic                full,
  output logic [1:0]          state
);

  localparam int unsigned W  = 4 * NDIGIT;
  localparam int unsigned CW = $clog2(NDIGIT + 1);
  localparam logic [CW-1:0] CntMax = CW'(NDIGIT);

  typedef enum logic [1:0] {StA = 2'b00, StB = 2'b01, StReq = 2'b10} state_e;

  state_e        st_q;
  logic [W-1:0]  a_q, b_q;
  logic [CW-1:0] cnt_a_q, cnt_b_q;
  logic [1:0]    op_q;
  logic          full_q, rv_q;

  logic          is_digit, is_op, do_clear;
  logic [1:0]    key_op;
  logic [W-1:0]  key_ext;
  logic [CW-1:0] cnt_sel;

  always_comb begin
    is_digit = (key_in <= 4'd9);
    is_op    = 1'b1;
    key_op   = 2'b00;
    if (key_in == KEY_ADD)      key_op = 2'b00;
    else if (key_in == KEY_SUB) key_op = 2'b01;
    else if (key_in == KEY_MUL) key_op = 2'b10;
    else                        is_op  = 1'b0;
    key_ext  = W'(key_in);
    // CLR and an accepted request both empty the register; CLR wins but the result is identical.
    do_clear = (key_valid && key_in == KEY_CLR) || (st_q == StReq && req_ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StA;
      a_q     <= '0;
      b_q     <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      op_q    <= 2'b00;
      full_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      full_q <= 1'b0;
      if (do_clear) begin
        st_q    <= StA;
        a_q     <= '0;
        b_q     <= '0;
        cnt_a_q <= '0;
        cnt_b_q <= '0;
        op_q    <= 2'b00;
        rv_q    <= 1'b0;
      end else if (key_valid) begin
        unique case (st_q)
          StA: begin
            if (is_digit) begin
              if (cnt_a_q < CntMax) begin
                a_q     <= (a_q << 4) | key_ext;
                cnt_a_q <= cnt_a_q + 1'b1;
              end else begin
                full_q <= 1'b1;
              end
            end else if (is_op) begin
              if (cnt_a_q != '0) begin
                op_q <= key_op;
                st_q <= StB;
              end
            end else if (key_in == KEY_BKSP && cnt_a_q != '0) begin
              a_q     <= a_q >> 4;
              cnt_a_q <= cnt_a_q - 1'b1;
            end
          end
          StB: begin
            if (is_digit) begin
              if (cnt_b_q < CntMax) begin
                b_q     <= (b_q << 4) | key_ext;
                cnt_b_q <= cnt_b_q + 1'b1;
              end else begin
                full_q <= 1'b1;
              end
            end else if (is_op) begin
              if (cnt_b_q == '0) op_q <= key_op;
            end else if (key_in == KEY_BKSP) begin
              if (cnt_b_q != '0) begin
                b_q     <= b_q >> 4;
                cnt_b_q <= cnt_b_q - 1'b1;
              end else begin
                st_q <= StA;
              end
            end else if (key_in == KEY_ENTER && cnt_b_q != '0) begin
              st_q <= StReq;
              rv_q <= 1'b1;
            end
          end
          StReq: ;
          default: begin
            st_q <= StA;
            rv_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Display follows the operand being edited; B stays on screen while the request is pending.
  always_comb begin
    disp          = (st_q == StA) ? a_q : b_q;
    cnt_sel       = (st_q == StA) ? cnt_a_q : cnt_b_q;
    disp_blank    = '0;
    for (int i = 1; i < NDIGIT; i++) begin
      disp_blank[i] = (CW'(i) >= cnt_sel);
    end
  end

  assign operand_a = a_q;
  assign operand_b = b_q;
  assign op_code   = op_q;
  assign req_valid = rv_q;
  assign full      = full_q;
  assign state     = st_q;

endmodule
